booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier: 8-bit signed × 8-bit signed gives a 16-bit signed product.
- Sits directly upstream of, and drives, the 8-bit ripple adder/subtractor RCAS8 (ports A1, A2, S, C, mode; mode=1 subtracts).
- Owns the operand registers, iteration counter and control FSM; issues one add, subtract or no-op per cycle and arithmetically shifts the result.
- Provides a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported because RCAS8 is fixed at 8 bits.
- CNT_W, 4, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- multiplicand  input  8  signed M; captured on the accepted start.
- multiplier  input  8  signed Q; captured on the accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  16  signed result; held until the next completion.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - A, Q, M, Q_1, count, product all cleared to 0.
  - busy=0, done=0.
  - Reset asserted mid-operation aborts the multiply immediately; no done pulse follows.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge loads A=0, Q=multiplier, Q_1=0, M=multiplicand, count=8, and moves to CALC.
  - start=0 stays in IDLE.
- CALC (one iteration per clock), driven by {Q[0],Q_1}:
  - 01: A1=A, A2=M, mode=0 (add).
  - 10: A1=A, A2=M, mode=1 (subtract).
  - 00 or 11: the adder result is ignored and R=A.
- CALC sign handling:
  - Overflow V=(A[7]==(M[7]^mode)) && (S[7]!=A[7]), valid only on an add or subtract.
  - True sign bit t = S[7]^V for add/subtract; t = A[7] for a no-op.
- CALC update, all on the same edge:
  - {A,Q,Q_1} <= {t, R, Q}, i.e. an arithmetic right shift of the 17-bit {R,Q,Q_1} with t as the shifted-in MSB.
  - count <= count-1.
  - When count==1 at the edge, go to DONE.
  - CALC therefore lasts exactly 8 cycles.
- The adder carry-out C is unused for arithmetic. The V correction makes multiplicand=-128 correct without a 9-bit accumulator.
- DONE:
  - done=1 for exactly one cycle.
  - product is loaded on the edge entering DONE, product={A,Q}.
  - Next edge goes unconditionally to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+8.
  - Back-to-back throughput is one multiply per 10 cycles: start can be re-sampled at edge k+10, its earliest acceptance.
- Ignored requests: start while in CALC or DONE is ignored, not queued. Operand input changes after capture have no effect.
- Output timing: done and busy are registered, decoded from state only, with no combinational path from start.
- product keeps its old value through a new CALC phase and updates only when entering DONE.
- When the multiplier is 0, Booth bit pairs are all 00 or 11; A stays sign-consistent and the result is exactly 0.

Decomposition:
- Shared package (booth_pkg):
  - state encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - constants WIDTH=8 and ITER=8.
  - Booth pair codes: ADD=2'b01, SUB=2'b10.
- One sub-module: the existing RCAS8, instantiated once, with A1=A, A2=M and mode driven from Q[0].
  - mode=Q[0] is sufficient: Q[0]=1 only subtracts for pair 10, and pair 11 takes the no-op path.
  - The no-op mux and the V logic stay in booth_mult_seq.

Test Plan:
- 3 × 5 → after 8 CALC cycles done=1 for 1 cycle, product=16'h000F; busy high for exactly 9 cycles.
- -3 (8'hFD) × 5 → product=16'hFFF1; 5 × -3 → 16'hFFF1; -7 × -9 → 16'h003F.
- -128 × -128 → 16'h4000; -128 × 127 → 16'hC080; 127 × 127 → 16'h3F01 (covers the overflow-sign correction).
- 0 × 8'hAB and 8'hAB × 0 → 16'h0000; done still pulses on the 9th cycle after start is sampled.
- Start 6 × 7, then pulse start with 2 × 2 at CALC cycle 3 → second request ignored, product=16'h002A, one done pulse only. Restart at the first IDLE cycle gives 16'h0004.
- Assert rst_n=0 at CALC cycle 4 → immediately busy=0, done=0, product=0, state=IDLE; no done pulse afterwards. A subsequent 3 × 5 yields 16'h000F.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// State encoding, operand width and Booth pair codes.
package booth_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;

  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;
endpackage

// File: rtl/booth_mult_seq_rcas8.sv
// RCAS8: 8-bit ripple-carry adder/subtractor.
// mode=1 computes A1-A2 as A1+~A2+1.
module RCAS8 (
  input  logic [7:0] A1,
  input  logic [7:0] A2,
  input  logic       mode,
  output logic [7:0] S,
  output logic       C
);
  logic       cy;
  logic [7:0] b;

  always_comb begin
    cy = mode;
    b  = A2 ^ {8{mode}};
    S  = '0;
    for (int i = 0; i < 8; i++) begin
      S[i] = A1[i] ^ b[i] ^ cy;
      cy   = (A1[i] & b[i]) |
             (cy & (A1[i] ^ b[i]));
    end
    C = cy;
  end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit.
// One add/sub/no-op per cycle through RCAS8, then arithmetic shift.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import booth_pkg::*;

  localparam int W = booth_pkg::WIDTH;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     m_q, m_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W-1:0] sum;
  logic [W-1:0] r;
  logic [1:0]   pair;
  logic         carry_unused;
  logic         is_op;
  logic         ovf;
  logic         t;

  RCAS8 u_rcas (
    .A1   (a_q),
    .A2   (m_q),
    .mode (q_q[0]),
    .S    (sum),
    .C    (carry_unused)
  );

  always_comb begin
    pair  = {q_q[0], q1_q};
    is_op = (pair == ADD) ||
            (pair == SUB);
    // V restores the true 9th-bit sign, so M=-128 needs no wider A.
    ovf   = is_op &&
            (a_q[W-1] == (m_q[W-1] ^ q_q[0])) &&
            (sum[W-1] != a_q[W-1]);
    r     = is_op ? sum : a_q;
    t     = is_op ? (sum[W-1] ^ ovf)
                  : a_q[W-1];

    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = CNT_W'(ITER);
          state_d = CALC;
        end
      end
      (state_q == CALC): begin
        a_d   = {t, r[W-1:1]};
        q_d   = {r[0], q_q[W-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          prod_d  = {a_d, q_d};
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq.
// Directed vectors push expectations; a monitor checks on done.
module tb_booth_mult_seq;
  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  mcand  = '0;
  logic [7:0]  mplier = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int busy_cnt = 0;
  int dones  = 0;
  int pushes = 0;

  logic [15:0] exp_q[$];
  int          start_q[$];
  logic [15:0] last_prod = '0;

  booth_mult_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    int          st;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done product=%h",
                   product);
        end else begin
          e  = exp_q.pop_front();
          st = start_q.pop_front();
          check("product", product, e);
          check("latency", cyc - st, 8);
          check("busy_cycles", busy_cnt, 9);
          last_prod = e;
        end
        busy_cnt = 0;
      end else if (busy) begin
        check("product_hold", product, last_prod);
      end
    end
  end

  task automatic run(input logic [7:0]  m,
                     input logic [7:0]  q,
                     input logic [15:0] e,
                     input bit          push);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%b", busy);
    end
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      start_q.push_back(cyc + 1);
      pushes++;
    end
    @(negedge clk);
    start  = 1'b0;
    mcand  = 8'h55;
    mplier = 8'hAA;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(8'd3,   8'd5,   16'h000F, 1);
    run(8'hFD,  8'd5,   16'hFFF1, 1);
    run(8'd5,   8'hFD,  16'hFFF1, 1);
    run(8'hF9,  8'hF7,  16'h003F, 1);
    run(8'h80,  8'h80,  16'h4000, 1);
    run(8'h80,  8'h7F,  16'hC080, 1);
    run(8'h7F,  8'h7F,  16'h3F01, 1);
    run(8'h00,  8'hAB,  16'h0000, 1);
    run(8'hAB,  8'h00,  16'h0000, 1);

    // Request during CALC must be dropped, not queued.
    run(8'd6, 8'd7, 16'h002A, 1);
    repeat (2) @(negedge clk);
    mcand  = 8'd2;
    mplier = 8'd2;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    run(8'd2, 8'd2, 16'h0004, 1);

    // Abort in CALC cycle 4.
    run(8'd3, 8'd5, 16'h0000, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    last_prod = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_idle", busy, 0);
    run(8'd3, 8'd5, 16'h000F, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pending", exp_q.size(), 0);
    check("done_count", dones, pushes);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
